regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised multi-read-port integer register file with a per-register scoreboard and optional write-to-read bypass, for the pipelined core. It replaces the fixed 32x32, two-read-port register file. Decode uses it to read operands and learn whether each operand is still pending. Issue uses it to reserve destination registers. Writeback writes results and releases the reservations.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, >= 2)
- NRD, 2, number of read ports
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = no forwarding
- ZERO_X0, 1, 1 = register 0 reads as zero, ignores writes and is never busy
- AW (derived, not overridable), $clog2(NREGS)
- CW (derived, not overridable), $clog2(NREGS+1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge)
- rd_addr  in  NRD*AW  read addresses; port k is bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port k is bits [k*XLEN +: XLEN]; combinational
- rd_busy  out  NRD  1 = operand k is still pending; combinational
- wr_en  in  1  writeback valid
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback value
- rsv_en  in  1  request to reserve a destination register
- rsv_addr  in  AW  register to reserve
- rsv_ready  out  1  reservation can be accepted this cycle; combinational
- flush  in  1  clear every busy bit (pipeline squash)
- busy_count  out  CW  number of busy registers; registered

## Operation
- State:
  - data array mem[NREGS] of XLEN bits
  - busy vector busy[NREGS]
  - busy_count register
- "x0 case" means ZERO_X0=1 and the address is 0.
- Read port k:
  - x0 case: rd_data=0 and rd_busy=0.
  - Bypass hit (BYPASS=1, reset=1, wr_en=1, wr_addr==rd_addr[k], not x0): rd_data=wr_data and rd_busy=0.
  - Otherwise: rd_data=mem[addr] and rd_busy=busy[addr].
- Write: when reset=1, wr_en=1 and not x0, mem[wr_addr] <= wr_data and busy[wr_addr] is cleared. A write to a register that is not busy is legal: the data is written and busy stays 0.
- Reserve:
  - rsv_ready = reset & ~flush & (x0 case | ~busy[rsv_addr] | (wr_en & wr_addr==rsv_addr)).
  - A reservation is accepted when rsv_en & rsv_ready. On acceptance busy[rsv_addr] <= 1, except x0 is accepted with no effect.
  - rsv_en with rsv_ready=0 is dropped. The requester must hold rsv_en until it sees rsv_ready.
- Same-address writeback and accepted reserve in one cycle: the set wins, so busy=1 afterwards. This is a new producer replacing the old one.
- Flush: when reset=1 and flush=1, all busy bits <= 0.
  - A write in the same cycle still updates mem.
  - A reserve in the same cycle is refused (rsv_ready=0).
- busy_count holds the population count of busy. It is updated on the same edge as busy, so it always matches the busy vector after the edge.
- Reset (reset=0 at an edge):
  - every mem word, every busy bit and busy_count are set to 0
  - writes and reserves in that cycle are ignored
  - rsv_ready=0 and the bypass is disabled while reset=0

## Timing
- Reads are combinational from the current state plus the same-cycle bypass. There is no read latency.
- Write and reserve take effect at the next rising edge.
- With BYPASS=1, a consumer sees a result in the same cycle as its writeback. With BYPASS=0, it sees the result one cycle later.
- rd_busy for a newly reserved register rises in the cycle after the accepting edge.
- busy_count lags the request by one edge. It is never combinational.
- Outputs after reset: rd_data=0, rd_busy=0, rsv_ready=1 (once reset=1 and flush=0), busy_count=0.
- Reset asserted mid-operation aborts all reservations at that edge. Nothing is retained.

## Structure
- Shared core package: regfile index width AW and the ZERO_X0 register index constant. These are reused by decode and hazard logic.
- One sub-module: popcount (parametrised width NREGS, output CW bits). It is used for the busy_count next-state value.
- The rest is flat: read muxes, bypass compare and scoreboard update.

## Test plan
- Reset then read: after reset=0 for one edge, read all 32 registers -> every rd_data=0, every rd_busy=0, busy_count=0.
- Reserve, then write back and read: reserve x5; next cycle read x5 -> rd_busy=1 and busy_count=1. Write x5=0xDEADBEEF while reading x5 -> with BYPASS=1, same cycle rd_data=0xDEADBEEF and rd_busy=0. Next cycle busy_count=0.
- x0 behaviour: reserve x0 and write x0=0x12345678 -> rd_data(x0)=0, rd_busy=0, busy_count unchanged.
- Collision: x7 busy; writeback x7 and reserve x7 in the same cycle -> rsv_ready=1. After the edge busy[x7]=1, mem[x7]=written value and busy_count unchanged.
- Flush: reserve x1, x2 and x3 (busy_count=3). Assert flush together with rsv_en for x4 and a write of x9=0xA5 -> rsv_ready=0. Next cycle busy_count=0, x4 not busy, mem[x9]=0xA5.
- Reset mid-operation: with 4 registers busy and data written, drive reset=0 for one edge -> all busy bits 0, all data 0, busy_count=0.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file constants used by the scoreboard, decode and hazard logic.
package regfile_scoreboard_pkg;

  localparam int unsigned DefaultXlen  = 32;
  localparam int unsigned DefaultNregs = 32;
  localparam int unsigned DefaultNrd   = 2;

  // Index width of the default architectural register file.
  localparam int unsigned RegAw = $clog2(DefaultNregs);

  // Register that reads as zero when the hard-wired-zero option is enabled.
  localparam int unsigned ZeroReg = 0;

  typedef logic [RegAw-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, writeback, reserve and flush signals between the pipeline and the register file.
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN  = DefaultXlen,
  parameter int unsigned NREGS = DefaultNregs,
  parameter int unsigned NRD   = DefaultNrd
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned CW = $clog2(NREGS + 1);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ready;
  logic                flush;
  logic [CW-1:0]       busy_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, rsv_ready, busy_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, rsv_ready, busy_count
  );

endinterface

// File: rtl/regfile_scoreboard_popcount.sv
// Combinational population count of a bit vector.
module regfile_scoreboard_popcount #(
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] bits_i,
  output logic [CntW-1:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < int'(Width); i++) begin
      count_o = count_o + CntW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register busy scoreboard and optional
// writeback-to-read bypass.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN    = DefaultXlen,
  parameter int unsigned NREGS   = DefaultNregs,
  parameter int unsigned NRD     = DefaultNrd,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_X0 = 1
) (
  input logic               clk,
  input logic               reset,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned CW = $clog2(NREGS + 1);

  logic [XLEN-1:0]     mem_q [NREGS];
  logic [NREGS-1:0]    busy_q, busy_d;
  logic [CW-1:0]       busy_count_q, busy_count_d;
  logic                wr_live, rsv_x0, rsv_ready, rsv_take;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;

  function automatic logic is_x0(input logic [AW-1:0] addr);
    return (ZERO_X0 != 0) && (addr == AW'(ZeroReg));
  endfunction

  assign wr_live = reset & bus.wr_en & ~is_x0(bus.wr_addr);
  assign rsv_x0  = is_x0(bus.rsv_addr);

  // A writeback to the requested register frees it this cycle, so the new
  // producer may take it over on the same edge.
  assign rsv_ready = reset & ~bus.flush &
                     (rsv_x0 | ~busy_q[bus.rsv_addr] |
                      (bus.wr_en & (bus.wr_addr == bus.rsv_addr)));
  assign rsv_take  = bus.rsv_en & rsv_ready & ~rsv_x0;

  always_comb begin
    busy_d = busy_q;
    if (wr_live) busy_d[bus.wr_addr] = 1'b0;
    // Set after clear: a same-address reserve replaces the retiring producer.
    if (rsv_take) busy_d[bus.rsv_addr] = 1'b1;
    if (bus.flush) busy_d = '0;
  end

  regfile_scoreboard_popcount #(
    .Width (NREGS),
    .CntW  (CW)
  ) u_popcount (
    .bits_i  (busy_d),
    .count_o (busy_count_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) mem_q[i] <= '0;
    end else if (wr_live) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    logic [AW-1:0] addr;
    rd_data = '0;
    rd_busy = '0;
    addr    = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      addr = bus.rd_addr[k*AW +: AW];
      if (is_x0(addr)) begin
        rd_data[k*XLEN +: XLEN] = '0;
        rd_busy[k]              = 1'b0;
      end else if ((BYPASS != 0) && wr_live && (bus.wr_addr == addr)) begin
        rd_data[k*XLEN +: XLEN] = bus.wr_data;
        rd_busy[k]              = 1'b0;
      end else begin
        rd_data[k*XLEN +: XLEN] = mem_q[addr];
        rd_busy[k]              = busy_q[addr];
      end
    end
  end

  assign bus.rd_data    = rd_data;
  assign bus.rd_busy    = rd_busy;
  assign bus.rsv_ready  = rsv_ready;
  assign bus.busy_count = busy_count_q;

endmodule
